// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// The master modport is the load/store unit; the slave modport is its environment.
interface load_store_unit_if;
    logic        reqValid;
    logic        reqReady;
    logic [3:0]  reqOp;
    logic [31:0] reqAddress;
    logic [31:0] reqStoreData;
    logic [4:0]  reqDest;

    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspData;
    logic [4:0]  rspDest;
    logic        rspWriteEnable;
    logic        rspAddressError;

    logic [31:0] memAddress;
    logic [31:0] memData;
    logic [2:0]  memWriteMode;
    logic [2:0]  memReadMode;
    logic        memUnsignedLoad;
    logic [31:0] memReadData;

    // Handshake: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid holds its payload stable until that edge.
    modport master (
        input  reqValid, reqOp, reqAddress, reqStoreData, reqDest, rspReady, memReadData,
        output reqReady, rspValid, rspData, rspDest, rspWriteEnable, rspAddressError,
        output memAddress, memData, memWriteMode, memReadMode, memUnsignedLoad
    );

    modport slave (
        output reqValid, reqOp, reqAddress, reqStoreData, reqDest, rspReady, memReadData,
        input  reqReady, rspValid, rspData, rspDest, rspWriteEnable, rspAddressError,
        input  memAddress, memData, memWriteMode, memReadMode, memUnsignedLoad
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, alignment check, LWL/LWR
// merge with the old rt value, and a valid/ready response channel.
module load_store_unit (
    input  logic                 clk,
    input  logic                 rst,
    load_store_unit_if.master    bus,
    output logic [1:0]           debugState
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESPOND = 2'd2} state_t;

    localparam logic [2:0] MODE_NONE = 3'd0;

    state_t      state, state_next;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [4:0]  dest_q;
    logic        err_q;

    function automatic logic is_load(input logic [3:0] op);
        return op <= 4'd6;
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd12);
    endfunction

    // Both loads (0..6) and stores (8..12) map onto BYTE..WORDRIGHT by their low bits.
    function automatic logic [2:0] mode_of(input logic [3:0] op);
        logic [2:0] m;
        m = MODE_NONE;
        if (is_load(op)) begin
            case (op[2:0])
                3'd0, 3'd1: m = 3'd1;
                3'd2, 3'd3: m = 3'd2;
                3'd4:       m = 3'd3;
                3'd5:       m = 3'd4;
                3'd6:       m = 3'd5;
                default:    m = MODE_NONE;
            endcase
        end else if (is_store(op)) begin
            m = op[2:0] + 3'd1;
        end
        return m;
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [31:0] addr);
        logic half_op, word_op;
        half_op = (op == 4'd2) || (op == 4'd3) || (op == 4'd9);
        word_op = (op == 4'd4) || (op == 4'd10);
        return (half_op && addr[0]) || (word_op && (addr[1:0] != 2'b00));
    endfunction

    logic        active;
    logic [5:0]  lwl_shift;
    logic [31:0] lwl_mask;
    logic [31:0] lwr_mask;
    logic [31:0] load_result;

    assign active = (state == ACCESS) && !err_q && (is_load(op_q) || is_store(op_q));

    // LWL keeps the low 8*(3-k) bits of rt, LWR keeps the high 8*k bits.
    assign lwl_shift = 6'd8 + {1'b0, addr_q[1:0], 3'b000};
    assign lwl_mask  = 32'hFFFF_FFFF >> lwl_shift;
    assign lwr_mask  = ~(32'hFFFF_FFFF >> {addr_q[1:0], 3'b000});

    always_comb begin
        load_result = bus.memReadData;
        if (op_q == 4'd5) load_result = bus.memReadData | (data_q & lwl_mask);
        if (op_q == 4'd6) load_result = bus.memReadData | (data_q & lwr_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            op_q                <= 4'd0;
            addr_q              <= 32'd0;
            data_q              <= 32'd0;
            dest_q              <= 5'd0;
            err_q               <= 1'b0;
            bus.rspData         <= 32'd0;
            bus.rspDest         <= 5'd0;
            bus.rspWriteEnable  <= 1'b0;
            bus.rspAddressError <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.reqValid) begin
                op_q   <= bus.reqOp;
                addr_q <= bus.reqAddress;
                data_q <= bus.reqStoreData;
                dest_q <= bus.reqDest;
                err_q  <= misaligned(bus.reqOp, bus.reqAddress);
            end
            if (state == ACCESS) begin
                bus.rspData         <= (active && is_load(op_q)) ? load_result : 32'd0;
                bus.rspDest         <= dest_q;
                bus.rspWriteEnable  <= active && is_load(op_q);
                bus.rspAddressError <= err_q;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.reqValid) state_next = ACCESS;
            ACCESS:  state_next = RESPOND;
            RESPOND: if (bus.rspReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.reqReady        = (state == IDLE);
        bus.rspValid        = (state == RESPOND);
        bus.memAddress      = 32'd0;
        bus.memData         = 32'd0;
        bus.memWriteMode    = MODE_NONE;
        bus.memReadMode     = MODE_NONE;
        bus.memUnsignedLoad = 1'b0;
        if (active) begin
            bus.memAddress = addr_q;
            if (is_load(op_q)) begin
                bus.memReadMode     = mode_of(op_q);
                bus.memUnsignedLoad = (op_q == 4'd1) || (op_q == 4'd3);
            end else begin
                bus.memWriteMode = mode_of(op_q);
                bus.memData      = data_q;
            end
        end
        // A reset edge must never coincide with a memory write.
        if (rst) bus.memWriteMode = MODE_NONE;
    end

    assign debugState = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit attached to a small little-endian behavioural memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] debug_state;
  int checks = 0;
  int errors = 0;

  // {addressError, writeEnable, dest[4:0], data[31:0]}
  logic [38:0] exp_q[$];

  load_store_unit_if b ();

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (b.master),
    .debugState (debug_state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural data memory ----------------
  logic [7:0]  mem [0:1023];
  logic [9:0]  rd_a;
  logic [31:0] rd_w;
  logic [15:0] rd_h;
  logic [31:0] rd_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [9:0] base;
    base = {a[9:2], 2'b00};
    return {mem[base + 10'd3], mem[base + 10'd2], mem[base + 10'd1], mem[base]};
  endfunction

  always_comb begin
    rd_a = b.memAddress[9:0];
    rd_w = mem_word(b.memAddress);
    rd_h = {mem[rd_a + 10'd1], mem[rd_a]};
    rd_data = 32'd0;
    case (b.memReadMode)
      3'd1: rd_data = b.memUnsignedLoad ? {24'd0, mem[rd_a]} : {{24{mem[rd_a][7]}}, mem[rd_a]};
      3'd2: rd_data = b.memUnsignedLoad ? {16'd0, rd_h} : {{16{rd_h[15]}}, rd_h};
      3'd3: rd_data = rd_w;
      3'd4: rd_data = rd_w << (8 * (3 - rd_a[1:0]));
      3'd5: rd_data = rd_w >> (8 * rd_a[1:0]);
      default: rd_data = 32'd0;
    endcase
  end
  assign b.memReadData = rd_data;

  always @(posedge clk) begin
    logic [9:0]  a;
    logic [9:0]  base;
    logic [31:0] sh;
    a = b.memAddress[9:0];
    base = {a[9:2], 2'b00};
    case (b.memWriteMode)
      3'd1: mem[a] <= b.memData[7:0];
      3'd2: begin mem[a] <= b.memData[7:0]; mem[a + 10'd1] <= b.memData[15:8]; end
      3'd3: for (int i = 0; i < 4; i++) mem[base + 10'(i)] <= b.memData[8*i +: 8];
      3'd4: begin
        sh = b.memData >> (8 * (3 - a[1:0]));
        for (int i = 0; i < 4; i++) if (i <= int'(a[1:0])) mem[base + 10'(i)] <= sh[8*i +: 8];
      end
      3'd5: begin
        sh = b.memData << (8 * a[1:0]);
        for (int i = 0; i < 4; i++) if (i >= int'(a[1:0])) mem[base + 10'(i)] <= sh[8*i +: 8];
      end
      default: ;
    endcase
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [38:0] mk(input logic err, input logic we, input logic [4:0] dest,
                                     input logic [31:0] data);
    return {err, we, dest, data};
  endfunction

  // Monitor: every accepted response is compared against the oldest expectation.
  always @(negedge clk) begin
    logic [38:0] e;
    if (!rst && b.rspValid && b.rspReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data %h dest %0d with no expectation", b.rspData, b.rspDest);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", b.rspData, e[31:0]);
        check("rsp_dest", {27'd0, b.rspDest}, {27'd0, e[36:32]});
        check("rsp_we", {31'd0, b.rspWriteEnable}, {31'd0, e[37]});
        check("rsp_err", {31'd0, b.rspAddressError}, {31'd0, e[38]});
      end
    end
  end

  // ---------------- driver ----------------
  logic [2:0]  rm, wm;
  logic [31:0] ma, md;
  logic        us;

  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [4:0] dest, input logic [38:0] exp,
                        output logic [2:0] rmode, output logic [2:0] wmode,
                        output logic [31:0] maddr, output logic [31:0] mdata, output logic uns);
    int n;
    @(negedge clk);
    n = 0;
    while (!b.reqReady && n < 50) begin @(negedge clk); n++; end
    check("req_ready_wait", {31'd0, b.reqReady}, 32'd1);
    b.reqValid = 1'b1;
    b.reqOp = op;
    b.reqAddress = addr;
    b.reqStoreData = rt;
    b.reqDest = dest;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 b.reqValid = 1'b0;
    @(negedge clk);
    rmode = b.memReadMode;
    wmode = b.memWriteMode;
    maddr = b.memAddress;
    mdata = b.memData;
    uns = b.memUnsignedLoad;
    check("lat_access_idle", {31'd0, b.rspValid}, 32'd0);
    @(negedge clk);
    check("lat_rsp_valid", {31'd0, b.rspValid}, 32'd1);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("rsp_drain", {31'd0, exp_q.size() == 0}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    b.reqValid = 1'b0;
    b.reqOp = 4'd0;
    b.reqAddress = 32'd0;
    b.reqStoreData = 32'd0;
    b.reqDest = 5'd0;
    b.rspReady = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wmode", {29'd0, b.memWriteMode}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, b.reqReady}, 32'd1);
    check("rst_rsp_valid", {31'd0, b.rspValid}, 32'd0);
    check("rst_rsp_data", b.rspData, 32'd0);
    check("rst_rsp_we", {31'd0, b.rspWriteEnable}, 32'd0);
    check("rst_rsp_err", {31'd0, b.rspAddressError}, 32'd0);
    check("rst_rmode", {29'd0, b.memReadMode}, 32'd0);
    check("rst_maddr", b.memAddress, 32'd0);
    check("rst_state", {30'd0, debug_state}, 32'd0);

    do_req(4'd10, 32'h100, 32'h1234_5678, 5'd3, mk(0, 0, 5'd3, 0), rm, wm, ma, md, us);
    check("sw_wmode", {29'd0, wm}, 32'd3);
    check("sw_maddr", ma, 32'h100);
    check("sw_mdata", md, 32'h1234_5678);
    check("sw_mem", mem_word(32'h100), 32'h1234_5678);

    do_req(4'd0, 32'h103, 32'h0, 5'd4, mk(0, 1, 5'd4, 32'h0000_0012), rm, wm, ma, md, us);
    check("lb_rmode", {29'd0, rm}, 32'd1);
    check("lb_maddr", ma, 32'h103);
    check("lb_wmode", {29'd0, wm}, 32'd0);
    do_req(4'd1, 32'h100, 32'h0, 5'd5, mk(0, 1, 5'd5, 32'h0000_0078), rm, wm, ma, md, us);
    check("lbu_unsigned", {31'd0, us}, 32'd1);
    do_req(4'd2, 32'h102, 32'h0, 5'd6, mk(0, 1, 5'd6, 32'h0000_1234), rm, wm, ma, md, us);
    check("lh_rmode", {29'd0, rm}, 32'd2);

    do_req(4'd9, 32'h104, 32'h0000_8001, 5'd1, mk(0, 0, 5'd1, 0), rm, wm, ma, md, us);
    do_req(4'd2, 32'h104, 32'h0, 5'd2, mk(0, 1, 5'd2, 32'hFFFF_8001), rm, wm, ma, md, us);
    do_req(4'd3, 32'h104, 32'h0, 5'd2, mk(0, 1, 5'd2, 32'h0000_8001), rm, wm, ma, md, us);
    do_req(4'd8, 32'h110, 32'h0000_0080, 5'd1, mk(0, 0, 5'd1, 0), rm, wm, ma, md, us);
    do_req(4'd0, 32'h110, 32'h0, 5'd8, mk(0, 1, 5'd8, 32'hFFFF_FF80), rm, wm, ma, md, us);

    do_req(4'd10, 32'h200, 32'hAABB_CCDD, 5'd1, mk(0, 0, 5'd1, 0), rm, wm, ma, md, us);
    do_req(4'd5, 32'h201, 32'h1122_3344, 5'd10, mk(0, 1, 5'd10, 32'hCCDD_3344), rm, wm, ma, md, us);
    check("lwl_rmode", {29'd0, rm}, 32'd4);
    do_req(4'd6, 32'h202, 32'h1122_3344, 5'd11, mk(0, 1, 5'd11, 32'h1122_AABB), rm, wm, ma, md, us);
    check("lwr_rmode", {29'd0, rm}, 32'd5);
    do_req(4'd5, 32'h203, 32'h1122_3344, 5'd12, mk(0, 1, 5'd12, 32'hAABB_CCDD), rm, wm, ma, md, us);
    do_req(4'd6, 32'h200, 32'h1122_3344, 5'd13, mk(0, 1, 5'd13, 32'hAABB_CCDD), rm, wm, ma, md, us);
    do_req(4'd4, 32'h200, 32'h0, 5'd14, mk(0, 1, 5'd14, 32'hAABB_CCDD), rm, wm, ma, md, us);

    // Misaligned accesses: no memory activity, error response.
    do_req(4'd4, 32'h102, 32'h0, 5'd15, mk(1, 0, 5'd15, 0), rm, wm, ma, md, us);
    check("err_lw_rmode", {29'd0, rm}, 32'd0);
    check("err_lw_maddr", ma, 32'd0);
    do_req(4'd9, 32'h101, 32'h0000_FFFF, 5'd16, mk(1, 0, 5'd16, 0), rm, wm, ma, md, us);
    check("err_sh_wmode", {29'd0, wm}, 32'd0);
    check("err_sh_mdata", md, 32'd0);
    check("err_mem_unchanged", mem_word(32'h100), 32'h1234_5678);

    // Back-pressure: response held, stray request ignored.
    @(negedge clk);
    b.rspReady = 1'b0;
    b.reqValid = 1'b1;
    b.reqOp = 4'd4;
    b.reqAddress = 32'h100;
    b.reqDest = 5'd7;
    exp_q.push_back(mk(0, 1, 5'd7, 32'h1234_5678));
    @(posedge clk);
    #1 b.reqValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, b.rspValid}, 32'd1);
      check("hold_data", b.rspData, 32'h1234_5678);
      check("hold_dest", {27'd0, b.rspDest}, 32'd7);
      check("hold_req_ready", {31'd0, b.reqReady}, 32'd0);
      if (i == 1) begin
        b.reqValid = 1'b1;
        b.reqOp = 4'd10;
        b.reqAddress = 32'h100;
        b.reqStoreData = 32'h0;
        b.reqDest = 5'd9;
      end
      if (i == 2) b.reqValid = 1'b0;
      @(negedge clk);
    end
    @(posedge clk);
    #1 b.rspReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_idle", {30'd0, debug_state}, 32'd0);
    check("release_req_ready", {31'd0, b.reqReady}, 32'd1);
    check("release_drained", {31'd0, exp_q.size() == 0}, 32'd1);
    check("ignored_req_mem", mem_word(32'h100), 32'h1234_5678);

    // Reset while a store is in ACCESS.
    @(negedge clk);
    b.reqValid = 1'b1;
    b.reqOp = 4'd10;
    b.reqAddress = 32'h300;
    b.reqStoreData = 32'hDEAD_BEEF;
    b.reqDest = 5'd20;
    @(posedge clk);
    #1 b.reqValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_access_wmode", {29'd0, b.memWriteMode}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_access_mem", mem_word(32'h300), 32'd0);
    check("rst_access_valid", {31'd0, b.rspValid}, 32'd0);
    check("rst_access_ready", {31'd0, b.reqReady}, 32'd1);
    @(negedge clk);
    check("rst_access_no_rsp", {31'd0, b.rspValid}, 32'd0);

    do_req(4'd12, 32'h302, 32'hA1B2_C3D4, 5'd21, mk(0, 0, 5'd21, 0), rm, wm, ma, md, us);
    check("swr_wmode", {29'd0, wm}, 32'd5);
    do_req(4'd4, 32'h300, 32'h0, 5'd22, mk(0, 1, 5'd22, 32'hC3D4_0000), rm, wm, ma, md, us);

    do_req(4'd7, 32'h100, 32'hFFFF_FFFF, 5'd23, mk(0, 0, 5'd23, 0), rm, wm, ma, md, us);
    check("nop_rmode", {29'd0, rm}, 32'd0);
    check("nop_wmode", {29'd0, wm}, 32'd0);
    check("nop_maddr", ma, 32'd0);
    do_req(4'd15, 32'h104, 32'h1, 5'd24, mk(0, 0, 5'd24, 0), rm, wm, ma, md, us);
    check("nop15_wmode", {29'd0, wm}, 32'd0);
    check("nop_mem_unchanged", mem_word(32'h100), 32'h1234_5678);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port: accepts one load/store request at a time from the CPU pipeline and drives the `Memory` block's address, data, write-mode and read-mode inputs. It checks alignment, returns load results through a valid/ready response channel, and merges LWL/LWR partial words with the old register value. Sits between the execute stage and `Memory`; the instruction-fetch port (`pcAddress`) is not driven by this block.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  block can accept a request; high only in IDLE.
- `reqOp`  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW, 11 SWL, 12 SWR; 7, 13–15 are NOP.
- `reqAddress`  in  32  effective byte address.
- `reqStoreData`  in  32  rt value: store data, and merge source for LWL/LWR.
- `reqDest`  in  5  destination register tag, passed through unchanged.
- `rspValid`  out  1  response present.
- `rspReady`  in  1  consumer accepts response.
- `rspData`  out  32  load result; 0 for stores, NOPs and errors.
- `rspDest`  out  5  registered `reqDest`.
- `rspWriteEnable`  out  1  1 only for a successful load.
- `rspAddressError`  out  1  misaligned LH/LHU/SH/LW/SW.
- `memAddress`  out  32  to `Memory.address`.
- `memData`  out  32  to `Memory.data`.
- `memWriteMode`  out  3  to `Memory.writeMode`: NONE 0, BYTE 1, HALFWORD 2, WORD 3, WORDLEFT 4, WORDRIGHT 5.
- `memReadMode`  out  3  to `Memory.readMode`, same encoding.
- `memUnsignedLoad`  out  1  to `Memory.unsignedLoad`.
- `memReadData`  in  32  from `Memory.dataOutput`; combinational read.

## Operation
- States: IDLE, ACCESS, RESPOND. Reset enters IDLE.
- IDLE: `reqReady`=1. When `reqValid` is high, register op, address, store data and dest, then go to ACCESS.
- Error check at accept:
  - LH/LHU/SH with addr[0]≠0 is an error.
  - LW/SW with addr[1:0]≠0 is an error.
  - LWL/LWR/SWL/SWR and byte ops are never misaligned.
- ACCESS, one cycle. Memory outputs are driven from registered values only in this state and only when the request is neither an error nor a NOP:
  - LB/LBU → readMode BYTE.
  - LH/LHU → HALFWORD.
  - LW → WORD.
  - LWL → WORDLEFT.
  - LWR → WORDRIGHT.
  - `memUnsignedLoad`=1 for LBU/LHU, otherwise 0.
  - Stores use writeMode with the same mapping; `memData`=stored rt.
  - `memAddress` = registered address.
  - On the edge leaving ACCESS, capture the result into `rspData` and go to RESPOND.
- Load merge, with k = addr[1:0]:
  - LWL: `rspData` = memReadData | (rt & mask); mask = low 8·(3−k) bits set (k=3 → 0).
  - LWR: `rspData` = memReadData | (rt & mask); mask = high 8·k bits set (k=0 → 0).
  - Other loads: `rspData` = memReadData unchanged (Memory does the sign extension).
- Store, NOP or error: `rspData`=0, `rspWriteEnable`=0. `rspAddressError`=1 only for errors.
- RESPOND: `rspValid`=1; all `rsp*` outputs hold stable. When `rspReady` is high, go to IDLE at that edge.
- Outside ACCESS, and on errors or NOPs: `memWriteMode`=`memReadMode`=NONE; `memAddress`, `memData`, `memUnsignedLoad` = 0.
- `memWriteMode` is forced to NONE combinationally while `rst`=1, so no memory write occurs on a reset edge.

## Timing
- Accept at edge N. ACCESS occupies cycle N..N+1. `rspValid` is high from edge N+1.
- Minimum 3 cycles per request.
- `reqReady` is combinational from state: 0 in ACCESS and RESPOND.
- A store's memory write happens at the edge ending ACCESS.
- Reset values: `rspValid`, `rspData`, `rspDest`, `rspWriteEnable`, `rspAddressError` = 0; all mem outputs = 0/NONE; `reqReady`=1 in the first cycle after reset.
- Reset in ACCESS: no write and no response. Reset in RESPOND: the response is dropped.
- `reqValid` is ignored outside IDLE.

## Test plan
- Bench connects the block to a `Memory` instance. SW 0x12345678 @0x100, then LB @0x103 → rspData 0x00000012, rspWriteEnable=1. LBU @0x100 → 0x00000078. LB of a byte 0x80 → 0xFFFFFF80.
- Word 0xAABBCCDD @0x200; LWL @0x201, rt=0x11223344 → rspData 0xCCDD3344. LWR @0x202, same rt → 0x1122AABB.
- LW @0x102 → rspAddressError=1, rspData=0, rspWriteEnable=0; mem modes stay NONE throughout; memory unchanged.
- Hold rspReady=0 for 5 cycles in RESPOND → rspValid=1 and rspData/rspDest stable; reqReady=0; a reqValid pulse is ignored. Raise rspReady → IDLE the next cycle.
- Assert rst during ACCESS of SW 0xDEADBEEF @0x300 → word @0x300 unchanged, rspValid=0, reqReady=1 after reset.
- NOP op 7 → response after 2 cycles with rspData=0, rspWriteEnable=0, rspAddressError=0; no mem activity.
